// File: rtl/uart_receive.sv
// Serial receiver for the UART transmitter's tx line: synchronises rx, samples each bit
// at mid-bit, and hands the word downstream through a one-deep valid/ready register.
module uart_receive #(
    parameter int d_width      = 6,
    parameter int c_width      = 4,
    parameter int clks_per_bit = 1,
    parameter int t_width      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_busy,
    output logic               rx_frame_err,
    output logic               rx_overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [t_width-1:0] T_BIT  = t_width'(clks_per_bit);
    localparam logic [t_width-1:0] T_HALF = t_width'(clks_per_bit / 2);
    localparam logic [t_width-1:0] T_ONE  = {{(t_width-1){1'b0}}, 1'b1};
    localparam logic [c_width-1:0] C_LAST = c_width'(d_width - 1);
    localparam logic [c_width-1:0] C_ONE  = {{(c_width-1){1'b0}}, 1'b1};
    localparam logic [c_width-1:0] C_ZERO = {c_width{1'b0}};
    localparam bit                 CPB_ONE = (clks_per_bit == 1);

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [t_width-1:0] timer_q, timer_d;
    logic [c_width-1:0] cnt_q, cnt_d;
    logic [d_width-1:0] shift_q, shift_d;
    logic [d_width-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic               rx_s;
    logic               sample_s;

    assign rx_s         = sync2_q;
    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_busy      = busy_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;

    // Next-state logic; the timer holds cycles elapsed since the last sample point.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + T_ONE;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q & ~rx_ready;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        sample_s = (timer_q == T_BIT);
        case (state_q)
            IDLE: begin
                timer_d = T_ONE;
                cnt_d   = C_ZERO;
                if (!rx_s) begin
                    // With one clock per bit the detection cycle is already the start sample.
                    state_d = CPB_ONE ? DATA : START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = T_ONE;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (sample_s) begin
                    timer_d = T_ONE;
                    shift_d = {rx_s, shift_q[d_width-1:1]};
                    if (cnt_q == C_LAST) begin
                        cnt_d   = C_ZERO;
                        state_d = STOP;
                    end else begin
                        cnt_d   = cnt_q + C_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (sample_s) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        // A handshake in the same cycle frees the register, so the load wins.
                        if (valid_q && !rx_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            timer_q <= {t_width{1'b0}};
            cnt_q   <= C_ZERO;
            shift_q <= {d_width{1'b0}};
            data_q  <= {d_width{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: one-bit-per-clock and 4x-oversampled instances checked every
// cycle against a sample-schedule model, plus directed literal expectations.
module tb_uart_receive;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx1, rdy1, valid1, busy1, ferr1, ovr1;
    logic       rx4, rdy4, valid4, busy4, ferr4, ovr4;
    logic [5:0] data1, data4;
    int         errors = 0;
    int         checks = 0;
    bit         rand_rdy = 1'b0;
    bit         e2e = 1'b0;
    int         ovr_seen1 = 0;
    int         n_hs = 0;
    int         n_ovr = 0;
    logic [5:0] sent[$];

    always #5 clk = ~clk;

    uart_receive #(.d_width(6), .c_width(4), .clks_per_bit(1), .t_width(8)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(data1), .rx_valid(valid1),
        .rx_ready(rdy1), .rx_busy(busy1), .rx_frame_err(ferr1), .rx_overrun(ovr1));

    uart_receive #(.d_width(6), .c_width(4), .clks_per_bit(4), .t_width(8)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .rx_data(data4), .rx_valid(valid4),
        .rx_ready(rdy4), .rx_busy(busy4), .rx_frame_err(ferr4), .rx_overrun(ovr4));

    typedef struct {
        bit         s1, s2;
        int         phase;   // 0 idle, 1 inside a frame, 2 waiting for line high
        int         t;       // cycles since the detection cycle S
        logic [5:0] word;
        logic [5:0] data;
        bit         valid, busy, ferr, ovr;
    } ms_t;

    ms_t m1, m4;

    function automatic ms_t mreset();
        ms_t r;
        r.s1 = 1'b1; r.s2 = 1'b1; r.phase = 0; r.t = 0; r.word = 6'h00; r.data = 6'h00;
        r.valid = 1'b0; r.busy = 1'b0; r.ferr = 1'b0; r.ovr = 1'b0;
        return r;
    endfunction

    // Bit k is read at S + k*cpb + cpb/2; k=0 start, 1..6 data, 7 stop.
    function automatic ms_t mstep(ms_t m, logic rxv, logic rdy, int cpb);
        ms_t n;
        int  k;
        bit  rs;
        n = m;
        rs = m.s2;
        n.s2 = m.s1;
        n.s1 = rxv;
        n.ferr = 1'b0;
        n.ovr = 1'b0;
        if (m.valid && rdy) n.valid = 1'b0;
        if (m.phase == 0 && !rs) begin
            n.phase = 1;
            n.t = 0;
        end else if (m.phase == 2 && rs) begin
            n.phase = 0;
        end
        if (n.phase == 1) begin
            if (n.t >= cpb / 2 && (n.t - cpb / 2) % cpb == 0) begin
                k = (n.t - cpb / 2) / cpb;
                if (k == 0) begin
                    if (rs) n.phase = 0;
                end else if (k <= 6) begin
                    n.word[k-1] = rs;
                end else if (rs) begin
                    n.phase = 0;
                    if (!m.valid || rdy) begin
                        n.data = n.word;
                        n.valid = 1'b1;
                    end else begin
                        n.ovr = 1'b1;
                    end
                end else begin
                    n.ferr = 1'b1;
                    n.phase = 2;
                end
            end
            n.t = n.t + 1;
        end
        n.busy = (n.phase != 0);
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 <= mreset();
            m4 <= mreset();
        end else begin
            m1 <= mstep(m1, rx1, rdy1, 1);
            m4 <= mstep(m4, rx4, rdy4, 4);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("d1_data", 32'(data1), 32'(m1.data));
        chk("d1_valid", 32'(valid1), 32'(m1.valid));
        chk("d1_busy", 32'(busy1), 32'(m1.busy));
        chk("d1_ferr", 32'(ferr1), 32'(m1.ferr));
        chk("d1_ovr", 32'(ovr1), 32'(m1.ovr));
        chk("d4_data", 32'(data4), 32'(m4.data));
        chk("d4_valid", 32'(valid4), 32'(m4.valid));
        chk("d4_busy", 32'(busy4), 32'(m4.busy));
        chk("d4_ferr", 32'(ferr4), 32'(m4.ferr));
        chk("d4_ovr", 32'(ovr4), 32'(m4.ovr));
    end

    // Pulse counter plus the end-to-end scoreboard: queue front is the held word.
    always @(negedge clk) begin
        if (ovr1) ovr_seen1++;
        if (e2e) begin
            if (ovr1) begin
                chk("e2e_ovr_queue", 32'(sent.size() >= 2), 32'd1);
                if (sent.size() >= 2) sent.delete(1);
                n_ovr++;
            end
            if (valid1 && rdy1) begin
                chk("e2e_hs_queue", 32'(sent.size() >= 1), 32'd1);
                if (sent.size() >= 1) begin
                    chk("e2e_word", 32'(data1), 32'(sent[0]));
                    void'(sent.pop_front());
                end
                n_hs++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 1) rx1 = v;
        else rx4 = v;
    endtask

    task automatic set_rdy(input int which, input logic v);
        if (which == 1) rdy1 = v;
        else rdy4 = v;
    endtask

    task automatic send_frame(input int which, input logic [5:0] w, input logic stop,
                              input int gap, input int rdy_at);
        logic [7:0] bits;
        int         cpb;
        int         idx;
        bits = {stop, w, 1'b0};
        cpb = (which == 1) ? 1 : 4;
        idx = 0;
        for (int b = 0; b < 8 + gap; b++) begin
            for (int c = 0; c < cpb; c++) begin
                set_line(which, (b < 8) ? bits[b] : 1'b1);
                if (rdy_at >= 0) set_rdy(which, idx == rdy_at);
                else if (rand_rdy) set_rdy(which, 1'($urandom_range(0, 1)));
                idx++;
                step();
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] bits;
        logic [5:0] w;
        int         first, nv, nb, nf, nvalid, base;
        rst = 1'b0; rx1 = 1'b1; rx4 = 1'b1; rdy1 = 1'b0; rdy4 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Reset in the middle of a frame, then a long idle line.
        set_line(1, 1'b0);
        repeat (4) step();
        chk("midframe_busy", 32'(busy1), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_line(1, 1'b1);
        repeat (20) step();
        chk("idle_data", 32'(data1), 32'd0);
        chk("idle_valid", 32'(valid1), 32'd0);
        chk("idle_busy", 32'(busy1), 32'd0);
        chk("idle_flags", 32'({ferr1, ovr1, ferr4, ovr4}), 32'd0);

        // Single frame at one clock per bit: valid at S+8 for one cycle.
        rdy1 = 1'b1;
        bits = {1'b1, 6'h2D, 1'b0};
        first = -1; nv = 0; w = 6'h00;
        for (int i = 0; i < 20; i++) begin
            set_line(1, (i < 8) ? bits[i] : 1'b1);
            step();
            if (valid1) begin
                nv++;
                w = data1;
                if (first < 0) first = i + 1;
            end
        end
        chk("frame_latency", 32'(first), 32'd10);
        chk("frame_data", 32'(w), 32'h2D);
        chk("frame_valid_cycles", 32'(nv), 32'd1);

        // Glitch on the oversampled link.
        set_line(4, 1'b0);
        step();
        set_line(4, 1'b1);
        nb = 0; nf = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            nb += int'(busy4);
            nf += int'(ferr4 | ovr4 | valid4);
        end
        chk("glitch_busy_cycles", 32'(nb), 32'd2);
        chk("glitch_flags", 32'(nf), 32'd0);

        // Stop bit 0, line held low afterwards.
        send_frame(4, 6'h0F, 1'b0, 0, -1);
        nf = 0; nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            nf += int'(ferr4);
            nvalid += int'(valid4);
        end
        chk("ferr_cycles", 32'(nf), 32'd1);
        chk("ferr_no_valid", 32'(nvalid), 32'd0);
        chk("break_busy", 32'(busy4), 32'd1);
        set_line(4, 1'b1);
        repeat (6) step();
        chk("break_exit_busy", 32'(busy4), 32'd0);

        // Good oversampled frame, consumed immediately.
        rdy4 = 1'b1;
        send_frame(4, 6'h2A, 1'b1, 2, -1);
        chk("cpb4_data", 32'(data4), 32'h2A);

        // Overrun: two back-to-back frames with nobody accepting.
        rdy1 = 1'b0;
        base = ovr_seen1;
        send_frame(1, 6'h15, 1'b1, 0, -1);
        send_frame(1, 6'h2A, 1'b1, 4, -1);
        chk("ovr_data_kept", 32'(data1), 32'h15);
        chk("ovr_valid", 32'(valid1), 32'd1);
        chk("ovr_pulses", 32'(ovr_seen1 - base), 32'd1);
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        step();
        chk("ovr_drain_valid", 32'(valid1), 32'd0);
        chk("ovr_drain_data", 32'(data1), 32'h15);

        // Handshake on the exact cycle the second word lands.
        base = ovr_seen1;
        send_frame(1, 6'h33, 1'b1, 0, -1);
        send_frame(1, 6'h0C, 1'b1, 3, 9);
        chk("simul_valid", 32'(valid1), 32'd1);
        chk("simul_data", 32'(data1), 32'h0C);
        chk("simul_no_ovr", 32'(ovr_seen1 - base), 32'd0);
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        step();

        // End-to-end: random words, random gaps, random ready.
        rand_rdy = 1'b1;
        e2e = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = 6'($urandom);
            sent.push_back(w);
            send_frame(1, w, 1'b1, $urandom_range(0, 2), -1);
        end
        rand_rdy = 1'b0;
        rdy1 = 1'b1;
        repeat (12) step();
        e2e = 1'b0;
        chk("e2e_queue_empty", 32'(sent.size()), 32'd0);
        chk("e2e_accounted", 32'(n_hs + n_ovr), 32'd40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
